// File: rtl/cube_sequencer.sv
// cube_sequencer: program sequencer for the cube-solver CPU; owns the PC, resolves JMP/JNZ/ZNJ, issues the rest.
// Latency: 3 cycles per issued instruction with exec_ready high (+ wait for check_done on CHECK), 2 per branch.
// Backpressure: exec_valid/exec_op held in ISSUE until exec_ready; one instruction outstanding, no prefetch.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    one-cycle pulse, (re)starts at START_PC from IDLE or HALT only
//   pc / op                  instruction address out, instruction in (combinational imem)
//   exec_valid/op/ready      issue handshake towards the execution datapath
//   check_done / check_hit   CHECK result pulse from the datapath, sampled only in WAIT_FLAG
//   flag, busy, halted       condition flag and status
//   retired                  saturating count of completed instructions
module cube_sequencer #(
    parameter int          PC_W     = 8,
    parameter int          OP_W     = 32,
    parameter int          CNT_W    = 16,
    parameter int unsigned START_PC = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [PC_W-1:0]  pc,
    input  logic [OP_W-1:0]  op,
    output logic             exec_valid,
    output logic [OP_W-1:0]  exec_op,
    input  logic             exec_ready,
    input  logic             check_done,
    input  logic             check_hit,
    output logic             flag,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);
    // Opcodes handled by the sequencer itself. Everything else (LI=1, ADD=2,
    // REFERENCE=4, RT*=5..7, STORE=8, unused codes) is passed to the datapath.
    localparam logic [3:0] OP_CHECK = 4'h3;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JNZ   = 4'hB;
    localparam logic [3:0] OP_ZNJ   = 4'hC;

    localparam logic [PC_W-1:0] START = PC_W'(START_PC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_FLAG,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [OP_W-1:0]  ir_q, ir_d;
    logic [OP_W-1:0]  exec_op_q, exec_op_d;
    logic             exec_valid_q, exec_valid_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [3:0]       ir_opc;
    logic [3:0]       exec_opc;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  pc_inc;
    logic [CNT_W-1:0] retired_inc;

    assign ir_opc      = ir_q[OP_W-1 -: 4];
    assign exec_opc    = exec_op_q[OP_W-1 -: 4];
    assign target      = ir_q[OP_W-5 -: PC_W];
    assign pc_inc      = pc_q + PC_W'(1);        // natural wrap at 2^PC_W
    assign retired_inc = (&retired_q) ? retired_q : retired_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        exec_op_d    = exec_op_q;
        exec_valid_d = exec_valid_q;
        flag_d       = flag_q;
        retired_d    = retired_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d      = START;
                    flag_d    = 1'b0;
                    retired_d = '0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = op;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (ir_opc)
                    OP_JMP: begin
                        // A jump onto itself marks the end of the program: park
                        // here without counting it.
                        if (target == pc_q) begin
                            state_d = S_HALT;
                        end else begin
                            pc_d      = target;
                            retired_d = retired_inc;
                            state_d   = S_FETCH;
                        end
                    end
                    OP_JNZ: begin
                        pc_d      = flag_q ? target : pc_inc;
                        retired_d = retired_inc;
                        state_d   = S_FETCH;
                    end
                    OP_ZNJ: begin
                        pc_d      = flag_q ? pc_inc : target;
                        retired_d = retired_inc;
                        state_d   = S_FETCH;
                    end
                    default: begin
                        exec_op_d    = ir_q;
                        exec_valid_d = 1'b1;
                        state_d      = S_ISSUE;
                    end
                endcase
            end
            S_ISSUE: begin
                if (exec_ready) begin
                    exec_valid_d = 1'b0;
                    retired_d    = retired_inc;
                    // CHECK keeps pc until its result arrives so the flag is
                    // settled before the following branch is decoded.
                    if (exec_opc == OP_CHECK) begin
                        state_d = S_WAIT_FLAG;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WAIT_FLAG: begin
                if (check_done) begin
                    flag_d  = check_hit;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= START;
            ir_q         <= '0;
            exec_op_q    <= '0;
            exec_valid_q <= 1'b0;
            flag_q       <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            exec_op_q    <= exec_op_d;
            exec_valid_q <= exec_valid_d;
            flag_q       <= flag_d;
            retired_q    <= retired_d;
        end
    end

    assign pc         = pc_q;
    assign exec_valid = exec_valid_q;
    assign exec_op    = exec_op_q;
    assign flag       = flag_q;
    assign retired    = retired_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_cube_sequencer.sv
`timescale 1ns/1ps
module tb_cube_sequencer;
    localparam logic [3:0] OP_LI    = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_CHECK = 4'h3;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JNZ   = 4'hB;
    localparam logic [3:0] OP_ZNJ   = 4'hC;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, exec_ready, check_done, check_hit;
    logic [7:0]  pc;
    logic [31:0] op, exec_op;
    logic        exec_valid, flag, busy, halted;
    logic [15:0] retired;

    logic [31:0] mem [256];
    assign op = mem[pc];

    cube_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .op(op),
        .exec_valid(exec_valid), .exec_op(exec_op), .exec_ready(exec_ready),
        .check_done(check_done), .check_hit(check_hit),
        .flag(flag), .busy(busy), .halted(halted), .retired(retired)
    );

    // Second instance with a 4-bit counter so saturation is reachable quickly.
    logic        rst_s, start_s;
    logic [7:0]  pc_s;
    logic [31:0] op_s, eop_s;
    logic        ev_s, fl_s, busy_s, halt_s;
    logic [3:0]  ret_s;
    assign op_s = (pc_s == 8'd0) ? {OP_JMP, 8'd1, 20'd0} : {OP_JMP, 8'd0, 20'd0};

    cube_sequencer #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst_s), .start(start_s), .pc(pc_s), .op(op_s),
        .exec_valid(ev_s), .exec_op(eop_s), .exec_ready(1'b1),
        .check_done(1'b0), .check_hit(1'b0),
        .flag(fl_s), .busy(busy_s), .halted(halt_s), .retired(ret_s)
    );

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] op;
        logic        flag;
        logic [15:0] ret;
    } item_t;

    item_t exp_q[$];
    int    hs_edge_q[$];
    logic  hits [64];
    int    hit_idx;
    bit    chk_pending;
    int    ready_mode;
    int    cyc;
    int    start_edge;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Ready driver: 0 = always ready, 1 = random backpressure, 2 = held low.
    initial begin
        exec_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                0:       exec_ready = 1'b1;
                1:       exec_ready = ($urandom_range(0, 9) < 7);
                default: exec_ready = 1'b0;
            endcase
        end
    end

    // Datapath stand-in for CHECK results, plus decoy check_done pulses while
    // an instruction is being offered (these must not touch the flag).
    initial begin : responder
        bit counting;
        int wait_n;
        counting   = 0;
        wait_n     = 0;
        check_done = 1'b0;
        check_hit  = 1'b0;
        forever begin
            @(posedge clk); #2;
            check_done = 1'b0;
            check_hit  = 1'b0;
            if (chk_pending) begin
                if (!counting) begin
                    counting = 1;
                    wait_n   = $urandom_range(0, 3);
                end
                if (wait_n == 0) begin
                    check_done  = 1'b1;
                    check_hit   = hits[hit_idx % 64];
                    hit_idx++;
                    chk_pending = 0;
                    counting    = 0;
                end else begin
                    wait_n--;
                end
            end else if (exec_valid && $urandom_range(0, 2) == 0) begin
                check_done = 1'b1;
                check_hit  = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: a handshake seen at the negedge completes on the next posedge.
    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clk);
            if (exec_valid && exec_ready) begin
                hs_edge_q.push_back(cyc + 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got op %0h at pc %0h expected none", exec_op, pc);
                end else begin
                    it = exp_q.pop_front();
                    chk("issue_op", exec_op, it.op);
                    chk("issue_pc", {24'd0, pc}, {24'd0, it.pc});
                    chk("issue_flag", {31'd0, flag}, {31'd0, it.flag});
                    chk("issue_retired", {16'd0, retired}, {16'd0, it.ret});
                end
                if (exec_op[31:28] == OP_CHECK) chk_pending = 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) mem[a] = {OP_JMP, 8'(a), 20'd0};
    endtask

    // ISA-level interpreter of the program in mem with the CHECK results in hits.
    task automatic model_run(output logic [7:0] fpc, output logic fflag,
                             output logic [15:0] fret, output bit ok);
        logic [7:0]  p;
        logic        f;
        logic [15:0] r;
        logic [31:0] o;
        int          k, steps;
        item_t       it;
        p = 8'd0; f = 1'b0; r = 16'd0; k = 0; steps = 0; ok = 0;
        while (!ok && steps < 2000) begin
            o = mem[p];
            steps++;
            if (o[31:28] == OP_JMP && o[27:20] == p) begin
                ok = 1;
            end else begin
                if (o[31:28] == OP_JMP) p = o[27:20];
                else if (o[31:28] == OP_JNZ) p = f ? o[27:20] : p + 8'd1;
                else if (o[31:28] == OP_ZNJ) p = f ? p + 8'd1 : o[27:20];
                else begin
                    it.pc = p; it.op = o; it.flag = f; it.ret = r;
                    exp_q.push_back(it);
                    if (o[31:28] == OP_CHECK) begin
                        f = hits[k % 64];
                        k++;
                    end
                    p = p + 8'd1;
                end
                if (r != 16'hFFFF) r = r + 16'd1;
            end
        end
        fpc = p; fflag = f; fret = r;
    endtask

    task automatic do_start();
        @(posedge clk); #2;
        start      = 1'b1;
        start_edge = cyc + 1;
        @(posedge clk); #2;
        start = 1'b0;
        chk("start_pc", {24'd0, pc}, 32'd0);
        chk("start_retired", {16'd0, retired}, 32'd0);
        chk("start_flag", {31'd0, flag}, 32'd0);
        chk("start_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic run_prog(input int exp_halt_pc);
        logic [7:0]  mpc;
        logic        mflag;
        logic [15:0] mret;
        bit          ok;
        int          n;
        model_run(mpc, mflag, mret, ok);
        hit_idx = 0;
        hs_edge_q.delete();
        do_start();
        n = 0;
        while (!halted && n < 3000) begin
            @(posedge clk); #2;
            n++;
            if (busy && $urandom_range(0, 7) == 0) begin
                start = 1'b1;           // must be ignored while busy
                @(posedge clk); #2;
                start = 1'b0;
                n++;
            end
        end
        chk("halted", {31'd0, halted}, 32'd1);
        chk("model_ok", {31'd0, ok}, 32'd1);
        chk("leftover_issues", exp_q.size(), 0);
        exp_q.delete();
        chk("halt_pc", {24'd0, pc}, {24'd0, mpc});
        chk("halt_retired", {16'd0, retired}, {16'd0, mret});
        chk("halt_flag", {31'd0, flag}, {31'd0, mflag});
        if (exp_halt_pc >= 0) chk("halt_pc_spec", {24'd0, pc}, exp_halt_pc);
    endtask

    initial begin : main
        int n;
        int ln;
        logic [3:0] oc;
        logic [15:0] prev;
        bit mono_bad;
        rst = 1'b0; rst_s = 1'b0; start = 1'b0; start_s = 1'b0;
        ready_mode = 0; chk_pending = 0; hit_idx = 0;
        for (int i = 0; i < 64; i++) hits[i] = 1'b0;
        clear_mem();
        #3 rst = 1'b1; rst_s = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_exec_valid", {31'd0, exec_valid}, 32'd0);
        chk("rst_exec_op", exec_op, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_retired", {16'd0, retired}, 32'd0);
        chk("rst_flag", {31'd0, flag}, 32'd0);
        rst = 1'b0; rst_s = 1'b0;

        // Straight-line program: issues every 3 cycles, halts at pc 3.
        clear_mem();
        mem[0] = {OP_LI, 28'h0000011};
        mem[1] = {OP_LI, 28'h0000022};
        mem[2] = {OP_LI, 28'h0000033};
        ready_mode = 0;
        run_prog(3);
        chk("line_retired", {16'd0, retired}, 32'd3);
        chk("line_issue_count", hs_edge_q.size(), 3);
        for (int i = 0; i < hs_edge_q.size() && i < 3; i++)
            chk("line_issue_cycle", hs_edge_q[i] - start_edge, 3 * (i + 1));

        // Backpressure on ADD: nothing moves until exec_ready, then exactly one advance.
        clear_mem();
        mem[0] = {OP_ADD, 28'h1234567};
        ready_mode = 2;
        exp_q.push_back('{pc: 8'd0, op: mem[0], flag: 1'b0, ret: 16'd0});
        do_start();
        n = 0;
        while (!exec_valid && n < 10) begin @(posedge clk); #2; n++; end
        chk("bp_valid_seen", {31'd0, exec_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            chk("bp_exec_op", exec_op, 32'h21234567);
            chk("bp_pc", {24'd0, pc}, 32'd0);
            chk("bp_retired", {16'd0, retired}, 32'd0);
        end
        ready_mode = 0;
        n = 0;
        while (!halted && n < 20) begin @(posedge clk); #2; n++; end
        chk("bp_halted", {31'd0, halted}, 32'd1);
        chk("bp_retired_after", {16'd0, retired}, 32'd1);
        chk("bp_pc_after", {24'd0, pc}, 32'd1);
        chk("bp_left", exp_q.size(), 0);

        // Reset while an ADD is stuck in ISSUE after one branch retired.
        clear_mem();
        mem[0] = {OP_ZNJ, 8'd1, 20'd0};
        mem[1] = {OP_ADD, 28'h0ABCDEF};
        ready_mode = 2;
        do_start();
        n = 0;
        while (!exec_valid && n < 10) begin @(posedge clk); #2; n++; end
        chk("rmid_valid_seen", {31'd0, exec_valid}, 32'd1);
        chk("rmid_retired_pre", {16'd0, retired}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rmid_exec_valid", {31'd0, exec_valid}, 32'd0);
        chk("rmid_pc", {24'd0, pc}, 32'd0);
        chk("rmid_retired", {16'd0, retired}, 32'd0);
        chk("rmid_flag", {31'd0, flag}, 32'd0);
        chk("rmid_busy", {31'd0, busy}, 32'd0);
        chk("rmid_halted", {31'd0, halted}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        ready_mode = 0;

        // CHECK then JNZ/ZNJ with both results.
        for (int v = 0; v < 4; v++) begin
            clear_mem();
            mem[0] = {OP_JMP, 8'd5, 20'd0};
            mem[5] = {OP_CHECK, 28'h0000555};
            mem[6] = {(v < 2) ? OP_JNZ : OP_ZNJ, 8'd20, 20'd0};
            hits[0] = v[0];
            run_prog(((v < 2) == v[0]) ? 20 : 7);
            chk("br_flag", {31'd0, flag}, {31'd0, v[0]});
        end

        // pc wrap 255 -> 0 after a non-control instruction.
        clear_mem();
        mem[0]   = {OP_ZNJ, 8'd254, 20'd0};
        mem[254] = {OP_CHECK, 28'h0000001};
        mem[255] = {OP_ADD, 28'h0000002};
        hits[0]  = 1'b1;
        run_prog(1);
        chk("wrap_retired", {16'd0, retired}, 32'd4);

        // Random forward-branching programs with random backpressure.
        ready_mode = 1;
        for (int t = 0; t < 20; t++) begin
            clear_mem();
            for (int i = 0; i < 64; i++) hits[i] = 1'($urandom_range(0, 1));
            ln = $urandom_range(3, 24);
            for (int i = 0; i < ln; i++) begin
                case ($urandom_range(0, 9))
                    0: mem[i] = {OP_JMP, 8'($urandom_range(i + 1, ln)), 20'($urandom)};
                    1: mem[i] = {OP_JNZ, 8'($urandom_range(i + 1, ln)), 20'($urandom)};
                    2: mem[i] = {OP_ZNJ, 8'($urandom_range(i + 1, ln)), 20'($urandom)};
                    3: mem[i] = {OP_CHECK, 28'($urandom)};
                    default: begin
                        oc = 4'($urandom_range(0, 15));
                        while (oc == OP_JMP || oc == OP_JNZ || oc == OP_ZNJ || oc == OP_CHECK)
                            oc = 4'($urandom_range(0, 15));
                        mem[i] = {oc, 28'($urandom)};
                    end
                endcase
            end
            run_prog(-1);
        end

        // Saturating retired counter on the 4-bit instance (endless JMP loop).
        @(posedge clk); #2;
        start_s = 1'b1;
        @(posedge clk); #2;
        start_s = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("sat_count_mid", {28'd0, ret_s}, 32'd5);
        prev = {12'd0, ret_s};
        mono_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #2;
            if ({12'd0, ret_s} < prev) mono_bad = 1;
            prev = {12'd0, ret_s};
        end
        chk("sat_monotonic", {31'd0, mono_bad}, 32'd0);
        chk("sat_value", {28'd0, ret_s}, 32'hF);
        chk("sat_busy", {31'd0, busy_s}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
